// File: rtl/fpadd_pkg.sv
// FP32 field layout, the canonical quiet NaN and the operand classification
// shared by the streaming adder control logic.
package fpadd_pkg;

   localparam int unsigned FP32_W        = 32;
   localparam int unsigned FP32_SIGN_POS = 31;
   localparam int unsigned FP32_EXP_MSB  = 30;
   localparam int unsigned FP32_EXP_LSB  = 23;
   localparam int unsigned FP32_EXP_W    = 8;
   localparam int unsigned FP32_MAN_MSB  = 22;
   localparam int unsigned FP32_MAN_W    = 23;

   localparam logic [FP32_W-1:0] FP32_QNAN = 32'h7FC0_0000;

   typedef struct packed {
      logic                  sign;
      logic [FP32_EXP_W-1:0] exponent;
      logic [FP32_MAN_W-1:0] mantissa;
   } fp32_t;

   // Inf/NaN (all-ones exponent) and subnormals fall outside the adder's
   // domain; signed zero is an ordinary operand.
   function automatic logic fp32_is_exc(input fp32_t v);
      logic exp_max;
      logic subnormal;
      exp_max   = (v.exponent == '1);
      subnormal = (v.exponent == '0) && (v.mantissa != '0);
      return exp_max || subnormal;
   endfunction

endpackage

// File: rtl/fpadd_result_fifo.sv
// Result FIFO: synchronous write/pop, registered head entry, occupancy count,
// asynchronous active-high reset. The head register is preloaded with the
// entry that will be at the head after each edge, bypassing the write data
// when the FIFO is (or is about to become) empty.
module fpadd_result_fifo
   import fpadd_pkg::*;
#(
   parameter int unsigned DEPTH  = 8,
   parameter int unsigned DATA_W = FP32_W + 5
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    wr_en,
   input  logic [DATA_W-1:0]       wr_data,
   input  logic                    rd_en,
   output logic [DATA_W-1:0]       rd_data,
   output logic [$clog2(DEPTH):0]  count,
   output logic                    empty
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [PTR_W-1:0]  rd_next;
   logic [CNT_W-1:0]  count_q;
   logic [CNT_W-1:0]  remain;
   logic [CNT_W-1:0]  count_next;
   logic [DATA_W-1:0] head_q;
   logic [DATA_W-1:0] head_d;
   logic              do_rd;

   assign do_rd = rd_en & (count_q != '0);

   // Next read pointer, occupancy and head entry after this edge.
   always_comb begin
      rd_next    = rd_ptr + PTR_W'(do_rd);
      remain     = count_q - CNT_W'(do_rd);
      count_next = remain + CNT_W'(wr_en);
      head_d     = '0;
      if (remain == '0) begin
         head_d = wr_en ? wr_data : '0;
      end else begin
         head_d = mem[rd_next];
      end
   end

   // Storage array; no reset needed, the head register masks stale slots.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   // Pointers, count and head register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
         head_q  <= '0;
      end else begin
         wr_ptr  <= wr_ptr + PTR_W'(wr_en);
         rd_ptr  <= rd_next;
         count_q <= count_next;
         head_q  <= head_d;
      end
   end

   assign rd_data = head_q;
   assign count   = count_q;
   assign empty   = (count_q == '0);

   wr_full_chk: assert property (@(posedge clk) disable iff (reset)
      !(wr_en && (count_q == CNT_W'(DEPTH))));

endmodule

// File: rtl/fpadd_stream_ctrl.sv
// Streaming control around the fixed-latency FP32 adder: valid/ready input,
// operand drive, in-flight tracking, result FIFO and credit-based admission.
// Optional operand classification is enabled by defining FPADD_EXC_CHECK_EN;
// when undefined, out_exc stays 0 and out_sum is the raw adder result.
module fpadd_stream_ctrl
   import fpadd_pkg::*;
#(
   parameter int unsigned LATENCY = 3,
   parameter int unsigned DEPTH   = 8,
   parameter int unsigned TAG_W   = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [31:0]       in_a,
   input  logic [31:0]       in_b,
   input  logic [TAG_W-1:0]  in_tag,
   output logic [31:0]       add_a,
   output logic [31:0]       add_b,
   input  logic [31:0]       add_result,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_sum,
   output logic [TAG_W-1:0]  out_tag,
   output logic              out_exc,
   output logic              busy
);

   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
   localparam int unsigned DW    = FP32_W + TAG_W + 1;

   logic               fire;
   logic               pop;
   logic               rst_done;
   logic               exc_in;
   logic [LATENCY-1:0] vpipe;
   logic [LATENCY-1:0] exc_pipe;
   logic [TAG_W-1:0]   tag_pipe [LATENCY];
   logic [CNT_W-1:0]   inflight;
   logic [CNT_W-1:0]   fifo_count;
   logic [CNT_W:0]     credits_used;
   logic               fifo_empty;
   logic [DW-1:0]      wr_data;
   logic [DW-1:0]      head;

   assign fire  = in_valid & in_ready;
   assign add_a = fire ? in_a : '0;
   assign add_b = fire ? in_b : '0;

`ifdef FPADD_EXC_CHECK_EN
   assign exc_in = fp32_is_exc(fp32_t'(in_a)) | fp32_is_exc(fp32_t'(in_b));
`else
   assign exc_in = 1'b0;
`endif

   // Holds in_ready low while reset is asserted, releasing on the first edge after.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rst_done <= 1'b0;
      end else begin
         rst_done <= 1'b1;
      end
   end

   // Tracking pipe: valid, tag and exception bit shadow the adder pipeline.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vpipe    <= '0;
         exc_pipe <= '0;
         for (int unsigned i = 0; i < LATENCY; i++) begin
            tag_pipe[i] <= '0;
         end
      end else begin
         vpipe[0]    <= fire;
         exc_pipe[0] <= exc_in;
         tag_pipe[0] <= in_tag;
         for (int unsigned i = 1; i < LATENCY; i++) begin
            vpipe[i]    <= vpipe[i-1];
            exc_pipe[i] <= exc_pipe[i-1];
            tag_pipe[i] <= tag_pipe[i-1];
         end
      end
   end

   // Number of pairs currently inside the adder pipeline.
   always_comb begin
      inflight = '0;
      for (int unsigned i = 0; i < LATENCY; i++) begin
         inflight = inflight + CNT_W'(vpipe[i]);
      end
   end

   // Each accepted pair holds a FIFO slot from accept until it is popped;
   // only registered state feeds the admission decision.
   assign credits_used = {1'b0, fifo_count} + {1'b0, inflight};
   assign in_ready     = rst_done && (credits_used < (CNT_W+1)'(DEPTH));

   assign wr_data = {exc_pipe[LATENCY-1], tag_pipe[LATENCY-1], add_result};
   assign pop     = out_valid & out_ready;

   fpadd_result_fifo #(
      .DEPTH  (DEPTH),
      .DATA_W (DW)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (vpipe[LATENCY-1]),
      .wr_data (wr_data),
      .rd_en   (pop),
      .rd_data (head),
      .count   (fifo_count),
      .empty   (fifo_empty)
   );

   assign out_valid = ~fifo_empty;
   assign out_tag   = head[FP32_W +: TAG_W];
   assign out_exc   = head[DW-1];
   assign busy      = (|vpipe) | (fifo_count != '0);

   // Result word: replaced by the quiet NaN when an operand was out of domain.
   always_comb begin
`ifdef FPADD_EXC_CHECK_EN
      out_sum = head[DW-1] ? FP32_QNAN : head[FP32_W-1:0];
`else
      out_sum = head[FP32_W-1:0];
`endif
   end

endmodule

// File: tb/tb_fpadd_stream_ctrl.sv
// Self-checking bench for fpadd_stream_ctrl with a behavioural adder model.
module tb_fpadd_stream_ctrl;

  localparam int unsigned LAT   = 3;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned TAG_W = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_a;
  logic [31:0]       in_b;
  logic [TAG_W-1:0]  in_tag;
  logic [31:0]       add_a;
  logic [31:0]       add_b;
  logic [31:0]       add_result;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_sum;
  logic [TAG_W-1:0]  out_tag;
  logic              out_exc;
  logic              busy;

  int nchecks = 0;
  int nfail   = 0;
  int unsigned cyc = 0;

  typedef struct {
    int unsigned      cyc;
    logic [31:0]      sum;
    logic [TAG_W-1:0] tag;
    logic             exc;
  } exp_t;

  exp_t q[$];
  bit   strict_lat = 1'b0;
  logic [31:0]      last_sum;
  logic [TAG_W-1:0] last_tag;
  logic             last_exc;
  int   n_acc;
  int   n_pop;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] expv);
    nchecks++;
    if (obs !== expv) begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", name, obs, expv);
    end
  endtask

  fpadd_stream_ctrl #(
    .LATENCY (LAT),
    .DEPTH   (DEPTH),
    .TAG_W   (TAG_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_tag     (in_tag),
    .add_a      (add_a),
    .add_b      (add_b),
    .add_result (add_result),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sum    (out_sum),
    .out_tag    (out_tag),
    .out_exc    (out_exc),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Integer-valued FP32 helpers (|v| < 2^23).
  function automatic logic [31:0] int_to_fp32(input int v);
    int unsigned mag;
    int          p;
    logic [31:0] m;
    if (v == 0) return 32'h0;
    mag = (v < 0) ? -v : v;
    p = 0;
    for (int i = 0; i < 24; i++) if (mag[i]) p = i;
    m = (mag << (23 - p)) & 32'h007F_FFFF;
    return {(v < 0) ? 1'b1 : 1'b0, 8'(127 + p), m[22:0]};
  endfunction

  function automatic int fp32_to_int(input logic [31:0] f);
    int e;
    int p;
    int mag;
    e = int'(f[30:23]);
    if (e == 0) return 0;
    p = e - 127;
    if (p < 0) return 0;
    mag = int'({8'h0, 1'b1, f[22:0]} >> (23 - p));
    return f[31] ? -mag : mag;
  endfunction

  function automatic logic [31:0] model_add(input logic [31:0] a, input logic [31:0] b);
    if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) return 32'h7F80_0000;
    return int_to_fp32(fp32_to_int(a) + fp32_to_int(b));
  endfunction

  function automatic logic model_exc(input logic [31:0] v);
    return (v[30:23] == 8'hFF) || (v[30:23] == 8'h00 && v[22:0] != 23'h0);
  endfunction

  // Behavioural adder: LAT register stages, reset shared with the DUT.
  logic [31:0] pa [LAT];
  logic [31:0] pb [LAT];
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < LAT; i++) begin
        pa[i] <= 32'h0;
        pb[i] <= 32'h0;
      end
    end else begin
      pa[0] <= add_a;
      pb[0] <= add_b;
      for (int i = 1; i < LAT; i++) begin
        pa[i] <= pa[i-1];
        pb[i] <= pb[i-1];
      end
    end
  end
  assign add_result = model_add(pa[LAT-1], pb[LAT-1]);

  // One clock cycle: drive inputs after negedge, check against the model.
  task automatic step(input logic iv, input logic [31:0] a, input logic [31:0] b,
                      input logic [TAG_W-1:0] t, input logic ordy);
    logic fire;
    logic exp_ov;
    exp_t e;
    @(negedge clk);
    in_valid  = iv;
    in_a      = a;
    in_b      = b;
    in_tag    = t;
    out_ready = ordy;
    #1;
    exp_ov = (q.size() != 0) && (q[0].cyc + LAT + 1 <= cyc);
    check("in_ready", in_ready, (q.size() < DEPTH));
    check("out_valid", out_valid, exp_ov);
    check("busy", busy, (q.size() != 0));
    fire = iv & in_ready;
    check("add_a", add_a, (fire ? a : 32'h0));
    check("add_b", add_b, (fire ? b : 32'h0));
    if (out_valid && ordy) begin
      check("result_expected", (q.size() != 0), 1'b1);
      if (q.size() != 0) begin
        check("out_sum", out_sum, q[0].sum);
        check("out_tag", out_tag, q[0].tag);
        check("out_exc", out_exc, q[0].exc);
        if (strict_lat) check("stream_latency", cyc, q[0].cyc + LAT + 1);
        void'(q.pop_front());
      end
      last_sum = out_sum;
      last_tag = out_tag;
      last_exc = out_exc;
      n_pop++;
    end
    if (fire) begin
      e.cyc = cyc;
      e.tag = t;
`ifdef FPADD_EXC_CHECK_EN
      e.exc = model_exc(a) | model_exc(b);
      e.sum = e.exc ? 32'h7FC0_0000 : model_add(a, b);
`else
      e.exc = 1'b0;
      e.sum = model_add(a, b);
`endif
      q.push_back(e);
      n_acc++;
    end
  endtask

  task automatic idle(input int n, input logic ordy);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, 32'h0, '0, ordy);
  endtask

  function automatic logic [31:0] rand_operand();
    int unsigned r;
    r = $urandom_range(0, 19);
    case (r)
      0:       return 32'h7F80_0000;
      1:       return 32'h0000_0001;
      2:       return 32'h8000_0000;
      3:       return 32'h7FC0_0000;
      default: return int_to_fp32(int'($urandom_range(0, 2000)) - 1000);
    endcase
  endfunction

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b1;
    in_a      = 32'h3F80_0000;
    in_b      = 32'h3F80_0000;
    in_tag    = '0;
    out_ready = 1'b1;
    last_sum  = '0;
    last_tag  = '0;
    last_exc  = 1'b0;
    n_acc     = 0;
    n_pop     = 0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_sum", out_sum, 32'h0);
    check("rst_out_tag", out_tag, 4'h0);
    check("rst_out_exc", out_exc, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_add_a", add_a, 32'h0);
    @(negedge clk);
    reset    = 1'b0;
    in_valid = 1'b0;

    // Single pair: 1.0 + 2.0, tag 5, result visible exactly LAT+1 cycles later
    step(1'b1, 32'h3F80_0000, 32'h4000_0000, 4'd5, 1'b0);
    idle(LAT, 1'b0);
    n_pop = 0;
    step(1'b0, 32'h0, 32'h0, '0, 1'b1);
    check("single_popped", n_pop, 1);
    check("single_sum", last_sum, 32'h4040_0000);
    check("single_tag", last_tag, 4'd5);
    idle(2, 1'b1);

    // Streaming: 16 back-to-back pairs k + 1.0
    strict_lat = 1'b1;
    for (int k = 0; k < 16; k++)
      step(1'b1, int_to_fp32(k), 32'h3F80_0000, TAG_W'(k), 1'b1);
    idle(LAT + 3, 1'b1);
    strict_lat = 1'b0;
    check("stream_last_tag", last_tag, 4'hF);
    check("stream_last_sum", last_sum, 32'h4180_0000);

    // Backpressure: consumer stalled, valid held high
    n_acc = 0;
    for (int k = 0; k < 14; k++)
      step(1'b1, int_to_fp32(k + 1), int_to_fp32(2 * k), TAG_W'(k), 1'b0);
    check("bp_accepts", n_acc, 8);
    n_pop = 0;
    idle(14, 1'b1);
    check("bp_pops", n_pop, 8);
    check("bp_last_tag", last_tag, 4'd7);

    // Cancellation: 1.0 + -1.0
    step(1'b1, 32'h3F80_0000, 32'hBF80_0000, 4'd3, 1'b1);
    idle(LAT + 2, 1'b1);
    check("cancel_sum", last_sum, 32'h0);
    check("cancel_exc", last_exc, 1'b0);

    // Exception operand: +Inf + 1.0
    step(1'b1, 32'h7F80_0000, 32'h3F80_0000, 4'd9, 1'b1);
    idle(LAT + 2, 1'b1);
`ifdef FPADD_EXC_CHECK_EN
    check("exc_flag", last_exc, 1'b1);
    check("exc_sum", last_sum, 32'h7FC0_0000);
`else
    check("exc_flag", last_exc, 1'b0);
`endif

    // Randomized traffic with random consumer stalls
    for (int k = 0; k < 300; k++)
      step(($urandom_range(0, 3) != 0), rand_operand(), rand_operand(),
           TAG_W'($urandom_range(0, 15)), ($urandom_range(0, 2) != 0));
    for (int k = 0; k < 40 && q.size() != 0; k++) idle(1, 1'b1);
    check("random_drained", q.size(), 0);
    idle(2, 1'b1);

    // Reset mid-flight: 3 pairs in the pipe, 2 in the FIFO
    for (int k = 0; k < 5; k++)
      step(1'b1, int_to_fp32(k), int_to_fp32(k), TAG_W'(k), 1'b0);
    @(negedge clk);
    reset    = 1'b1;
    in_valid = 1'b0;
    #1;
    check("midrst_in_ready", in_ready, 1'b0);
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_busy", busy, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    q.delete();
    n_pop = 0;
    idle(10, 1'b1);
    check("midrst_no_result", n_pop, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nchecks, nfail);
    $finish;
  end

endmodule
